stream_rr_arbiter: RTL and testbench

Round-robin arbiter that merges four 32-bit valid/ready stream requesters onto one shared downstream stream link. It lets the four picorv32 stream output ports, or any four producers with the same handshake, share a single consumer channel without loss. Grants are held for bursts of up to `MAX_BURST` beats. Output data passes through a one-entry registered stage.

---
 rtl/stream_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_stream_rr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Four-port round-robin stream arbiter with burst-limited grants and a one-entry output register.
// Optional STREAM_ARB_SRC_TAG_EN adds a src_id register tagging each output beat with its source port.
module stream_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  val_in1,
  input  logic                  val_in2,
  input  logic                  val_in3,
  input  logic                  val_in4,
  output logic                  ready_upward1,
  output logic                  ready_upward2,
  output logic                  ready_upward3,
  output logic                  ready_upward4,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [DATA_WIDTH-1:0] din4,
  output logic                  val_out,
  input  logic                  ready_downward,
  output logic [DATA_WIDTH-1:0] dout,
`ifdef STREAM_ARB_SRC_TAG_EN
  output logic [1:0]            src_id,
`endif
  output logic [3:0]            grant
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                       state;
  logic [7:0]                   cnt;
  logic [1:0]                   last;
  logic [3:0]                   vin;
  logic [3:0]                   rdy;
  logic [3:0][DATA_WIDTH-1:0]   din_a;
  logic                         load_en;
  logic                         xfer;
  logic                         gval;
  logic [1:0]                   gidx;
  logic                         pick_vld;
  logic [1:0]                   pick_idx;
  logic [1:0]                   idx;

  assign vin     = {val_in4, val_in3, val_in2, val_in1};
  assign din_a   = {din4, din3, din2, din1};
  assign load_en = !val_out || ready_downward;
  // grant is zero in IDLE, so this alone keeps every ready low there
  assign rdy     = grant & {4{load_en}};
  assign xfer    = |(vin & rdy);
  assign gval    = |(vin & grant);

  assign ready_upward1 = rdy[0];
  assign ready_upward2 = rdy[1];
  assign ready_upward3 = rdy[2];
  assign ready_upward4 = rdy[3];

  always_comb begin
    gidx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (grant[i]) gidx = 2'(i);
  end

  // Scan last+4 down to last+1 so the nearest valid port after last wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last;
    idx      = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (vin[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      grant   <= 4'b0000;
      cnt     <= 8'd0;
      last    <= 2'd3;
      val_out <= 1'b0;
      dout    <= '0;
`ifdef STREAM_ARB_SRC_TAG_EN
      src_id  <= 2'd0;
`endif
    end else begin
      if (xfer) begin
        dout    <= din_a[gidx];
        val_out <= 1'b1;
`ifdef STREAM_ARB_SRC_TAG_EN
        src_id  <= gidx;
`endif
      end else if (ready_downward) begin
        val_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= 4'(1) << pick_idx;
            last  <= pick_idx;
            cnt   <= 8'd0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!gval || (xfer && cnt == 8'(MAX_BURST - 1))) begin
            grant <= 4'b0000;
            state <= IDLE;
          end else if (xfer) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed-sequence bench for stream_rr_arbiter (default MAX_BURST=4).
// Define STREAM_ARB_SRC_TAG_EN for both files to also check src_id.
module tb_stream_rr_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  vin;
  logic [31:0] din [4];
  logic        ready_downward;
  logic        ready_upward1, ready_upward2, ready_upward3, ready_upward4;
  logic        val_out;
  logic [31:0] dout;
  logic [3:0]  grant;
  logic [3:0]  rdy;
  int          seq [4];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ph, p, beat;
`ifdef STREAM_ARB_SRC_TAG_EN
  logic [1:0]  src_id;
`endif

  always #5 clk = ~clk;

  assign rdy = {ready_upward4, ready_upward3, ready_upward2, ready_upward1};

  stream_rr_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .resetn(resetn),
    .val_in1(vin[0]), .val_in2(vin[1]), .val_in3(vin[2]), .val_in4(vin[3]),
    .ready_upward1(ready_upward1), .ready_upward2(ready_upward2),
    .ready_upward3(ready_upward3), .ready_upward4(ready_upward4),
    .din1(din[0]), .din2(din[1]), .din3(din[2]), .din4(din[3]),
    .val_out(val_out), .ready_downward(ready_downward), .dout(dout),
`ifdef STREAM_ARB_SRC_TAG_EN
    .src_id(src_id),
`endif
    .grant(grant)
  );

  function automatic logic [31:0] dat(int port, int n);
    return (32'(port + 1) << 16) | 32'(n);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic upd_din();
    for (int i = 0; i < 4; i++) din[i] = dat(i, seq[i]);
  endtask

  // Advance one clock; each producer moves to its next word after an accepted beat.
  task automatic tick();
    logic [3:0] x;
    #1;
    x = vin & rdy;
    @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) if (x[i]) seq[i]++;
    upd_din();
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    vin = 4'b0000;
    ready_downward = 1'b1;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    upd_din();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    vin = 4'b0000;
    ready_downward = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 32'd0;

    // Reset values and single-port burst of three beats
    reset_dut();
    chk("rst_val_out", 32'(val_out), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
`ifdef STREAM_ARB_SRC_TAG_EN
    chk("rst_src_id", 32'(src_id), 32'd0);
`endif
    vin = 4'b0001;
    #1;
    chk("t1_idle_ready", 32'(rdy), 32'd0);
    tick();
    chk("t1_grant", 32'(grant), 32'b0001);
    chk("t1_ready1", 32'(rdy), 32'b0001);
    chk("t1_val_T1", 32'(val_out), 32'd0);
    tick();
    chk("t1_val_T2", 32'(val_out), 32'd1);
    chk("t1_dout0", dout, dat(0, 0));
    tick();
    chk("t1_dout1", dout, dat(0, 1));
    tick();
    chk("t1_dout2", dout, dat(0, 2));
    vin = 4'b0000;
    tick();
    chk("t1_idle_grant", 32'(grant), 32'd0);
    chk("t1_idle_val", 32'(val_out), 32'd0);

    // Full contention: 4 beats per port, one bubble between grants, wrap to port1
    reset_dut();
    vin = 4'b1111;
    for (int k = 1; k <= 22; k++) begin
      tick();
      ph = (k - 1) % 5;
      p = ((k - 1) / 5) % 4;
      if (ph == 0) begin
        chk("t2_bubble_val", 32'(val_out), 32'd0);
        chk("t2_new_grant", 32'(grant), 32'(1) << p);
      end else begin
        beat = ((k - 1) / 20) * 4 + ph - 1;
        chk("t2_val", 32'(val_out), 32'd1);
        chk("t2_dout", dout, dat(p, beat));
        chk("t2_grant", 32'(grant), (ph == 4) ? 32'd0 : (32'(1) << p));
`ifdef STREAM_ARB_SRC_TAG_EN
        chk("t2_src_id", 32'(src_id), 32'(p));
`endif
      end
    end

    // Backpressure for five cycles while port2 holds the grant
    reset_dut();
    vin = 4'b0010;
    tick();
    chk("t3_grant", 32'(grant), 32'b0010);
    tick();
    chk("t3_val", 32'(val_out), 32'd1);
    chk("t3_dout0", dout, dat(1, 0));
    ready_downward = 1'b0;
    #1;
    chk("t3_bp_ready_now", 32'(rdy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_bp_dout", dout, dat(1, 0));
      chk("t3_bp_val", 32'(val_out), 32'd1);
      chk("t3_bp_ready", 32'(rdy), 32'd0);
    end
    ready_downward = 1'b1;
    #1;
    chk("t3_resume_ready", 32'(rdy), 32'b0010);
    tick();
    chk("t3_dout1", dout, dat(1, 1));
    tick();
    chk("t3_dout2", dout, dat(1, 2));
    tick();
    chk("t3_dout3", dout, dat(1, 3));
    chk("t3_cap_grant", 32'(grant), 32'd0);
    tick();
    chk("t3_regrant", 32'(grant), 32'b0010);
    chk("t3_bubble_val", 32'(val_out), 32'd0);

    // Early release: port1 drops after two beats, port3 waiting
    reset_dut();
    vin = 4'b0101;
    tick();
    chk("t4_grant1", 32'(grant), 32'b0001);
    tick();
    chk("t4_dout0", dout, dat(0, 0));
    tick();
    chk("t4_dout1", dout, dat(0, 1));
    vin[0] = 1'b0;
    tick();
    chk("t4_release_grant", 32'(grant), 32'd0);
    chk("t4_release_val", 32'(val_out), 32'd0);
    tick();
    chk("t4_grant3", 32'(grant), 32'b0100);
    vin[0] = 1'b1;
    tick();
    chk("t4_p3_dout0", dout, dat(2, 0));
    chk("t4_p3_hold", 32'(grant), 32'b0100);
    tick();
    tick();
    tick();
    chk("t4_p3_dout3", dout, dat(2, 3));
    chk("t4_p3_done", 32'(grant), 32'd0);
    tick();
    chk("t4_port1_next", 32'(grant), 32'b0001);

    // Reset in the middle of a port2 burst
    reset_dut();
    vin = 4'b0010;
    tick();
    tick();
    chk("t5_pre_val", 32'(val_out), 32'd1);
    resetn = 1'b0;
    vin = 4'b1111;
    tick();
    chk("t5_rst_val", 32'(val_out), 32'd0);
    chk("t5_rst_dout", dout, 32'd0);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_ready", 32'(rdy), 32'd0);
    resetn = 1'b1;
    tick();
    chk("t5_first_grant", 32'(grant), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
